scoreboard: RTL and testbench

Game-state and scoring block for the whack-a-mole design. Tracks a countdown game timer and a 2-digit BCD hit score, and drives the four BCD digit inputs of the seven-segment display driver directly (timer on the left pair, score on the right pair). Consumes 1-cycle event pulses from the mole/button logic and a 1 Hz tick from the clock divider.

---
 rtl/scoreboard_if.sv | 23 ++
 rtl/scoreboard.sv | 112 +++++++++++
 tb/tb_scoreboard.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_if.sv
// Event/display bundle between the whack-a-mole game logic and the scoreboard.
interface scoreboard_if;
   logic       start;
   logic       hit;
   logic       miss;
   logic       sec_tick;
   logic [3:0] digit_1;
   logic [3:0] digit_2;
   logic [3:0] digit_3;
   logic [3:0] digit_4;
   logic       running;
   logic       game_over;

   modport master (
      output start, hit, miss, sec_tick,
      input  digit_1, digit_2, digit_3, digit_4, running, game_over
   );

   modport slave (
      input  start, hit, miss, sec_tick,
      output digit_1, digit_2, digit_3, digit_4, running, game_over
   );
endinterface

// File: rtl/scoreboard.sv
// Countdown timer and 2-digit BCD score for whack-a-mole, driving the display digits.
// Optional SCOREBOARD_PENALTY_EN: miss decrements the score (floor 00).
module scoreboard #(
   parameter int unsigned GAME_SECS = 60
) (
   input  logic       clk,
   input  logic       rst,
   scoreboard_if.slave sb
);

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   localparam logic [3:0] LOAD_TENS = 4'(GAME_SECS / 10);
   localparam logic [3:0] LOAD_ONES = 4'(GAME_SECS % 10);

`ifdef SCOREBOARD_PENALTY_EN
   localparam logic PENALTY = 1'b1;
`else
   localparam logic PENALTY = 1'b0;
`endif

   state_t     r_state, w_state_nxt;
   logic [3:0] r_t10, r_t1, r_s10, r_s1;
   logic [3:0] w_t10_nxt, w_t1_nxt, w_s10_nxt, w_s1_nxt;
   logic       r_running, r_game_over;
   logic       w_miss, w_inc, w_dec;
   logic       w_score_max, w_score_min;

   // hit and miss together cancel when penalties are enabled
   assign w_miss      = sb.miss & PENALTY;
   assign w_inc       = sb.hit & ~w_miss;
   assign w_dec       = w_miss & ~sb.hit;
   assign w_score_max = (r_s10 == 4'd9) && (r_s1 == 4'd9);
   assign w_score_min = (r_s10 == 4'd0) && (r_s1 == 4'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_t10_nxt   = r_t10;
      w_t1_nxt    = r_t1;
      w_s10_nxt   = r_s10;
      w_s1_nxt    = r_s1;
      unique case (r_state)
         IDLE, OVER: begin
            if (sb.start) begin
               w_state_nxt = RUN;
               w_t10_nxt   = LOAD_TENS;
               w_t1_nxt    = LOAD_ONES;
               w_s10_nxt   = '0;
               w_s1_nxt    = '0;
            end
         end
         RUN: begin
            if (sb.sec_tick) begin
               // timer at 01 (or 00) expires instead of borrowing below zero
               if ((r_t10 == 4'd0) && (r_t1 <= 4'd1)) begin
                  w_t1_nxt    = '0;
                  w_state_nxt = OVER;
               end else if (r_t1 == 4'd0) begin
                  w_t1_nxt  = 4'd9;
                  w_t10_nxt = r_t10 - 4'd1;
               end else begin
                  w_t1_nxt = r_t1 - 4'd1;
               end
            end
            if (w_inc && !w_score_max) begin
               if (r_s1 == 4'd9) begin
                  w_s1_nxt  = '0;
                  w_s10_nxt = r_s10 + 4'd1;
               end else begin
                  w_s1_nxt = r_s1 + 4'd1;
               end
            end else if (w_dec && !w_score_min) begin
               if (r_s1 == 4'd0) begin
                  w_s1_nxt  = 4'd9;
                  w_s10_nxt = r_s10 - 4'd1;
               end else begin
                  w_s1_nxt = r_s1 - 4'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_t10       <= LOAD_TENS;
         r_t1        <= LOAD_ONES;
         r_s10       <= '0;
         r_s1        <= '0;
         r_running   <= 1'b0;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_t10       <= w_t10_nxt;
         r_t1        <= w_t1_nxt;
         r_s10       <= w_s10_nxt;
         r_s1        <= w_s1_nxt;
         r_running   <= (w_state_nxt == RUN);
         r_game_over <= (w_state_nxt == OVER);
      end
   end

   assign sb.digit_1   = r_t10;
   assign sb.digit_2   = r_t1;
   assign sb.digit_3   = r_s10;
   assign sb.digit_4   = r_s1;
   assign sb.running   = r_running;
   assign sb.game_over = r_game_over;

endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: integer game model checked every cycle, plus directed literal checks.
module tb_scoreboard;

`ifdef SCOREBOARD_PENALTY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst60, rst3;
   bit   armed = 1'b0;
   int   total = 0;
   int   bad   = 0;

   // model state per DUT: 0 idle, 1 run, 2 over; timer and score as plain integers
   int m_st[2];
   int m_t[2];
   int m_s[2];

   always #5 clk = ~clk;

   scoreboard_if sb60 ();
   scoreboard_if sb3 ();

   scoreboard #(.GAME_SECS(60)) dut60 (.clk(clk), .rst(rst60), .sb(sb60));
   scoreboard #(.GAME_SECS(3))  dut3  (.clk(clk), .rst(rst3),  .sb(sb3));

   function automatic logic [23:0] pk(input int r, input int o, input int a, input int b,
                                      input int c, input int d);
      return {3'b0, r[0], 3'b0, o[0], a[3:0], b[3:0], c[3:0], d[3:0]};
   endfunction

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_step(input int i, input int gs, input logic r, input logic s,
                             input logic h, input logic m, input logic t);
      if (r) begin
         m_st[i] = 0; m_t[i] = gs; m_s[i] = 0;
      end else if (m_st[i] != 1) begin
         if (s) begin
            m_st[i] = 1; m_t[i] = gs; m_s[i] = 0;
         end
      end else begin
         m_s[i] = m_s[i] + (h ? 1 : 0) - ((PEN && m) ? 1 : 0);
         if (m_s[i] > 99) m_s[i] = 99;
         if (m_s[i] < 0)  m_s[i] = 0;
         if (t) begin
            m_t[i] = m_t[i] - 1;
            if (m_t[i] == 0) m_st[i] = 2;
         end
      end
   endtask

   always @(posedge clk) begin
      model_step(0, 60, rst60, sb60.start, sb60.hit, sb60.miss, sb60.sec_tick);
      model_step(1, 3,  rst3,  sb3.start,  sb3.hit,  sb3.miss,  sb3.sec_tick);
   end

   function automatic logic [23:0] model_pk(input int i);
      return pk(m_st[i] == 1, m_st[i] == 2, m_t[i] / 10, m_t[i] % 10, m_s[i] / 10, m_s[i] % 10);
   endfunction

   function automatic logic [23:0] pk60();
      return pk(sb60.running, sb60.game_over, sb60.digit_1, sb60.digit_2, sb60.digit_3, sb60.digit_4);
   endfunction

   function automatic logic [23:0] pk3();
      return pk(sb3.running, sb3.game_over, sb3.digit_1, sb3.digit_2, sb3.digit_3, sb3.digit_4);
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         chk("model60", pk60(), model_pk(0));
         chk("model3",  pk3(),  model_pk(1));
         total++;
         if (sb60.digit_1 > 4'd9 || sb60.digit_2 > 4'd9 || sb60.digit_3 > 4'd9 || sb60.digit_4 > 4'd9 ||
             sb3.digit_1 > 4'd9 || sb3.digit_2 > 4'd9 || sb3.digit_3 > 4'd9 || sb3.digit_4 > 4'd9) begin
            bad++;
            $display("FAIL bcd_range actual60=%h actual3=%h required every digit <= 9", pk60(), pk3());
         end
      end
   end

   task automatic step60(input logic s, input logic h, input logic m, input logic t);
      sb60.start = s; sb60.hit = h; sb60.miss = m; sb60.sec_tick = t;
      @(posedge clk); #1;
      sb60.start = 1'b0; sb60.hit = 1'b0; sb60.miss = 1'b0; sb60.sec_tick = 1'b0;
   endtask

   task automatic step3(input logic s, input logic h, input logic m, input logic t);
      sb3.start = s; sb3.hit = h; sb3.miss = m; sb3.sec_tick = t;
      @(posedge clk); #1;
      sb3.start = 1'b0; sb3.hit = 1'b0; sb3.miss = 1'b0; sb3.sec_tick = 1'b0;
   endtask

   task automatic reset60();
      rst60 = 1'b1;
      step60(1'b1, 1'b1, 1'b0, 1'b1);
      rst60 = 1'b0;
   endtask

   initial begin
      rst60 = 1'b1; rst3 = 1'b1;
      sb60.start = 1'b0; sb60.hit = 1'b0; sb60.miss = 1'b0; sb60.sec_tick = 1'b0;
      sb3.start  = 1'b0; sb3.hit  = 1'b0; sb3.miss  = 1'b0; sb3.sec_tick  = 1'b0;
      @(posedge clk); #1;
      armed = 1'b1;
      step60(1'b0, 1'b0, 1'b0, 1'b0);
      rst60 = 1'b0; rst3 = 1'b0;
      chk("reset60", pk60(), pk(0, 0, 6, 0, 0, 0));
      chk("reset3",  pk3(),  pk(0, 0, 0, 3, 0, 0));

      repeat (5) step60(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step60(1'b0, 1'b1, 1'b0, 1'b0);
      chk("idle_ignore", pk60(), pk(0, 0, 6, 0, 0, 0));

      step60(1'b1, 1'b0, 1'b0, 1'b0);
      chk("start", pk60(), pk(1, 0, 6, 0, 0, 0));
      repeat (10) step60(1'b0, 1'b1, 1'b0, 1'b0);
      chk("hits10", pk60(), pk(1, 0, 6, 0, 1, 0));
      step60(1'b0, 1'b0, 1'b0, 1'b1);
      chk("timer_borrow", pk60(), pk(1, 0, 5, 9, 1, 0));
      step60(1'b1, 1'b0, 1'b0, 1'b0);
      chk("start_in_run", pk60(), pk(1, 0, 5, 9, 1, 0));
      repeat (105) step60(1'b0, 1'b1, 1'b0, 1'b0);
      chk("score_saturate", pk60(), pk(1, 0, 5, 9, 9, 9));

      reset60();
      chk("rst_hit_discard", pk60(), pk(0, 0, 6, 0, 0, 0));
      step60(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (10) step60(1'b0, 1'b1, 1'b0, 1'b0);
      step60(1'b0, 1'b0, 1'b1, 1'b0);
      chk("miss_at_10", pk60(), pk(1, 0, 6, 0, PEN ? 0 : 1, PEN ? 9 : 0));
      step60(1'b0, 1'b1, 1'b1, 1'b0);
      chk("hit_miss", pk60(), pk(1, 0, 6, 0, PEN ? 0 : 1, PEN ? 9 : 1));
      repeat (12) step60(1'b0, 1'b0, 1'b1, 1'b0);
      chk("miss_floor", pk60(), pk(1, 0, 6, 0, PEN ? 0 : 1, PEN ? 0 : 1));
      step60(1'b0, 1'b1, 1'b1, 1'b0);
      chk("hit_miss_00", pk60(), pk(1, 0, 6, 0, PEN ? 0 : 1, PEN ? 0 : 2));
      repeat (100) step60(1'b0, 1'b1, 1'b0, 1'b0);
      step60(1'b0, 1'b1, 1'b1, 1'b0);
      chk("hit_miss_99", pk60(), pk(1, 0, 6, 0, 9, 9));

      reset60();
      step60(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (42) step60(1'b0, 1'b1, 1'b0, 1'b0);
      repeat (43) step60(1'b0, 1'b0, 1'b0, 1'b1);
      chk("pre_rst", pk60(), pk(1, 0, 1, 7, 4, 2));
      reset60();
      chk("rst_mid_run", pk60(), pk(0, 0, 6, 0, 0, 0));

      step60(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (60) step60(1'b0, 1'b0, 1'b0, 1'b1);
      chk("full_game60", pk60(), pk(0, 1, 0, 0, 0, 0));

      step3(1'b1, 1'b1, 1'b0, 1'b0);
      chk("start_hit_idle", pk3(), pk(1, 0, 0, 3, 0, 0));
      step3(1'b0, 1'b0, 1'b0, 1'b1);
      step3(1'b0, 1'b0, 1'b0, 1'b1);
      chk("timer3_01", pk3(), pk(1, 0, 0, 1, 0, 0));
      step3(1'b0, 1'b1, 1'b0, 1'b1);
      chk("final_tick_hit", pk3(), pk(0, 1, 0, 0, 0, 1));
      step3(1'b0, 1'b1, 1'b0, 1'b0);
      step3(1'b0, 1'b0, 1'b0, 1'b1);
      step3(1'b0, 1'b0, 1'b1, 1'b0);
      chk("over_frozen", pk3(), pk(0, 1, 0, 0, 0, 1));
      step3(1'b1, 1'b1, 1'b0, 1'b0);
      chk("restart_over", pk3(), pk(1, 0, 0, 3, 0, 0));

      repeat (3) step3(1'b0, 1'b0, 1'b0, 1'b0);
      armed = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
